// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero register 0, write-to-read bypass and a sequenced sweep-clear engine.
module reg_file_param #(
    parameter int WIDTH    = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             Clk,
    input  logic             Clear_n,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [AW-1:0]    Aaddr,
    input  logic [AW-1:0]    Baddr,
    input  logic [AW-1:0]    Caddr,
    input  logic             Load,
    input  logic             Sweep,
    output logic             Busy,
    output logic             Done,
    output logic             WrErr
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              wrErr_q, wrErr_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic              writeEn;
    logic              zeroTarget;

    assign zeroTarget = (ZERO_REG != 0) && (Caddr == '0);

    // Sweep request beats a same-edge Load; any Load not taken in IDLE is flagged.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        wrErr_d = 1'b0;
        writeEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (Sweep) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    wrErr_d = Load;
                end else if (Load && !zeroTarget) begin
                    writeEn = 1'b1;
                end
            end
            SWEEP: begin
                wrErr_d = Load;
                ptr_d   = ptr_q + AW'(1);
                if (&ptr_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            wrErr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            wrErr_q <= wrErr_d;
        end
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEn) begin
            regs_q[Caddr] <= C;
        end else if (state_q == SWEEP) begin
            regs_q[ptr_q] <= '0;
        end
    end

    // writeEn is never set while sweeping or for a zeroed register 0, so bypass inherits both exclusions.
    always_comb begin
        A = regs_q[Aaddr];
        if ((BYPASS != 0) && writeEn && (Caddr == Aaddr)) begin
            A = C;
        end
        if ((ZERO_REG != 0) && (Aaddr == '0)) begin
            A = '0;
        end
    end

    always_comb begin
        B = regs_q[Baddr];
        if ((BYPASS != 0) && writeEn && (Caddr == Baddr)) begin
            B = C;
        end
        if ((ZERO_REG != 0) && (Baddr == '0)) begin
            B = '0;
        end
    end

    assign Busy  = (state_q == SWEEP);
    assign Done  = done_q;
    assign WrErr = wrErr_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: default instance, a zero-reg/no-bypass
// instance sharing its inputs, and a 32-bit x 8-entry instance.
module tb_reg_file_param;

    logic        Clk;
    logic        Clear_n;
    logic [15:0] C;
    logic [3:0]  Aaddr, Baddr, Caddr;
    logic        Load, Sweep;

    logic [15:0] A, B;
    logic        Busy, Done, WrErr;
    logic [15:0] A2, B2;
    logic        Busy2, Done2, WrErr2;

    logic [31:0] cW;
    logic [2:0]  aAddrW, bAddrW, cAddrW;
    logic        loadW, sweepW;
    logic [31:0] A3, B3;
    logic        Busy3, Done3, WrErr3;

    int vectors = 0;
    int errors  = 0;

    reg_file_param dut (
        .Clk(Clk), .Clear_n(Clear_n), .A(A), .B(B), .C(C),
        .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr),
        .Load(Load), .Sweep(Sweep), .Busy(Busy), .Done(Done), .WrErr(WrErr)
    );

    reg_file_param #(.ZERO_REG(1), .BYPASS(0)) dut2 (
        .Clk(Clk), .Clear_n(Clear_n), .A(A2), .B(B2), .C(C),
        .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr),
        .Load(Load), .Sweep(Sweep), .Busy(Busy2), .Done(Done2), .WrErr(WrErr2)
    );

    reg_file_param #(.WIDTH(32), .AW(3)) dut3 (
        .Clk(Clk), .Clear_n(Clear_n), .A(A3), .B(B3), .C(cW),
        .Aaddr(aAddrW), .Baddr(bAddrW), .Caddr(cAddrW),
        .Load(loadW), .Sweep(sweepW), .Busy(Busy3), .Done(Done3), .WrErr(WrErr3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic stepClock(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic sw, input logic [3:0] ca,
                                 input logic [15:0] cd, input logic [3:0] aa, input logic [3:0] ba);
        Load  = ld;
        Sweep = sw;
        Caddr = ca;
        C     = cd;
        Aaddr = aa;
        Baddr = ba;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Clear_n = 1'b1;
        Load = 0; Sweep = 0; C = '0; Aaddr = '0; Baddr = '0; Caddr = '0;
        loadW = 0; sweepW = 0; cW = '0; aAddrW = '0; bAddrW = '0; cAddrW = '0;

        // Asynchronous reset asserted between edges
        #3 Clear_n = 1'b0;
        #1;
        checkOutput("reset_A", A, 16'h0000);
        checkOutput("reset_B", B, 16'h0000);
        checkOutput("reset_Busy", Busy, 1'b0);
        checkOutput("reset_Done", Done, 1'b0);
        checkOutput("reset_WrErr", WrErr, 1'b0);
        stepClock(2);
        Clear_n = 1'b1;

        // Basic write then read
        applyStimulus(1, 0, 4'd5, 16'hBEEF, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd5, 4'd5);
        checkOutput("rd_A_r5", A, 16'hBEEF);
        checkOutput("rd_B_r5", B, 16'hBEEF);

        // Bypass vs no-bypass
        applyStimulus(1, 0, 4'd3, 16'h1111, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(1, 0, 4'd4, 16'h4444, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(1, 0, 4'd3, 16'h2222, 4'd3, 4'd4);
        checkOutput("byp_A", A, 16'h2222);
        checkOutput("byp_B", B, 16'h4444);
        checkOutput("nobyp_A", A2, 16'h1111);
        checkOutput("nobyp_B", B2, 16'h4444);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd3, 4'd4);
        checkOutput("post_A", A, 16'h2222);
        checkOutput("nobyp_post_A", A2, 16'h2222);

        // Register 0: writable in default instance, hardwired in zero-reg instance
        applyStimulus(1, 0, 4'd0, 16'hFFFF, 4'd0, 4'd0);
        checkOutput("zr_pre_A2", A2, 16'h0000);
        checkOutput("r0_byp_A", A, 16'hFFFF);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd0, 4'd0);
        checkOutput("zr_post_A2", A2, 16'h0000);
        checkOutput("zr_WrErr2", WrErr2, 1'b0);
        checkOutput("r0_post_A", A, 16'hFFFF);

        // Fill, then sweep-clear
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 4'(i), 16'(i), 4'd0, 4'd0);
            stepClock(1);
        end
        applyStimulus(0, 1, 4'd0, 16'h0000, 4'd4, 4'd4);
        checkOutput("fill_r4", A, 16'h0004);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd4, 4'd4);
        checkOutput("sw_Busy_t", Busy, 1'b1);
        checkOutput("sw_Done_t", Done, 1'b0);
        stepClock(4);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd3, 4'd4);
        checkOutput("sw4_r3", A, 16'h0000);
        checkOutput("sw4_r4", B, 16'h0004);
        stepClock(11);
        checkOutput("sw_Busy_15", Busy, 1'b1);
        checkOutput("sw_Done_15", Done, 1'b0);
        stepClock(1);
        checkOutput("sw_Busy_16", Busy, 1'b0);
        checkOutput("sw_Done_16", Done, 1'b1);
        stepClock(1);
        checkOutput("sw_Done_17", Done, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 4'd0, 16'h0000, 4'(i), 4'd0);
            checkOutput($sformatf("sw_clr_r%0d", i), A, 16'h0000);
        end

        // Load rejected while busy
        applyStimulus(1, 0, 4'd7, 16'h7777, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(0, 1, 4'd0, 16'h0000, 4'd7, 4'd0);
        stepClock(1);
        applyStimulus(1, 0, 4'd7, 16'hAAAA, 4'd7, 4'd0);
        checkOutput("busy_nobyp_r7", A, 16'h7777);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd7, 4'd0);
        checkOutput("rej_WrErr", WrErr, 1'b1);
        stepClock(1);
        checkOutput("rej_WrErr_clr", WrErr, 1'b0);
        stepClock(14);
        checkOutput("rej_Done", Done, 1'b1);
        checkOutput("rej_r7", A, 16'h0000);

        // Sweep accepted in the Done cycle
        applyStimulus(0, 1, 4'd0, 16'h0000, 4'd7, 4'd0);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd7, 4'd0);
        checkOutput("redo_Busy", Busy, 1'b1);
        checkOutput("redo_Done", Done, 1'b0);
        stepClock(16);
        checkOutput("redo_Done_end", Done, 1'b1);

        // Sweep and Load on the same idle edge
        applyStimulus(1, 0, 4'd9, 16'h9999, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(1, 1, 4'd9, 16'h5555, 4'd9, 4'd0);
        checkOutput("swld_nobyp", A, 16'h9999);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd9, 4'd0);
        checkOutput("swld_WrErr", WrErr, 1'b1);
        checkOutput("swld_Busy", Busy, 1'b1);
        checkOutput("swld_r9", A, 16'h9999);
        stepClock(16);
        checkOutput("swld_Done", Done, 1'b1);

        // Reset in the middle of a sweep
        applyStimulus(1, 0, 4'd10, 16'h0A0A, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(0, 1, 4'd0, 16'h0000, 4'd10, 4'd0);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd10, 4'd0);
        stepClock(5);
        checkOutput("mid_r10", A, 16'h0A0A);
        Clear_n = 1'b0;
        #1;
        checkOutput("mid_rst_Busy", Busy, 1'b0);
        checkOutput("mid_rst_r10", A, 16'h0000);
        stepClock(2);
        checkOutput("mid_rst_Done", Done, 1'b0);
        Clear_n = 1'b1;
        applyStimulus(0, 1, 4'd0, 16'h0000, 4'd0, 4'd0);
        stepClock(1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 4'd0, 4'd0);
        checkOutput("rs_Busy_t", Busy, 1'b1);
        stepClock(15);
        checkOutput("rs_Busy_15", Busy, 1'b1);
        stepClock(1);
        checkOutput("rs_Busy_16", Busy, 1'b0);
        checkOutput("rs_Done_16", Done, 1'b1);

        // 32-bit x 8-entry instance
        loadW = 1; cAddrW = 3'd7; cW = 32'hDEADBEEF;
        stepClock(1);
        loadW = 0; aAddrW = 3'd7; bAddrW = 3'd7;
        #1;
        checkOutput("w32_A", A3, 32'hDEADBEEF);
        checkOutput("w32_B", B3, 32'hDEADBEEF);
        sweepW = 1;
        stepClock(1);
        sweepW = 0;
        checkOutput("w32_Busy_t", Busy3, 1'b1);
        stepClock(7);
        checkOutput("w32_Busy_7", Busy3, 1'b1);
        stepClock(1);
        checkOutput("w32_Busy_8", Busy3, 1'b0);
        checkOutput("w32_Done_8", Done3, 1'b1);
        checkOutput("w32_r7_clr", A3, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
